// File: rtl/tap_pkg.sv
// rtl/tap_pkg.sv - TAP state encoding and instruction-register constants
package tap_pkg;

    // Bit 3 marks the IR column; TLR is all-ones so a stuck-high decode lands in reset.
    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_IDLE         = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_e;

    // Value loaded into the IR in Capture-IR; truncated to the IR width by the user.
    localparam logic [7:0] IR_CAPTURE = 8'h01;

    // BYPASS is all-ones at any IR width; truncate to the IR width at the call site.
    function automatic logic [7:0] bypass_opcode();
        return 8'hFF;
    endfunction

endpackage

// File: rtl/tap_controller_ir_if.sv
// rtl/tap_controller_ir_if.sv - JTAG pin, strobe and decode bundle for the TAP
interface tap_controller_ir_if #(
    parameter int IR_WIDTH = 4
);
    logic                TMS;
    logic                TDI;
    logic                bsr_tdo;
    logic                TDO;
    logic                tdo_en;
    logic                clockdr;
    logic                shiftdr;
    logic                updatedr;
    logic                clockir;
    logic                shiftir;
    logic                updateir;
    logic                select;
    logic                bs_en;
    logic                sel_bsr;
    logic                extest;
    logic [IR_WIDTH-1:0] instr;
    logic [3:0]          tap_state;

    modport master (
        output TMS, TDI, bsr_tdo,
        input  TDO, tdo_en, clockdr, shiftdr, updatedr, clockir, shiftir, updateir,
        input  select, bs_en, sel_bsr, extest, instr, tap_state
    );

    modport slave (
        input  TMS, TDI, bsr_tdo,
        output TDO, tdo_en, clockdr, shiftdr, updatedr, clockir, shiftir, updateir,
        output select, bs_en, sel_bsr, extest, instr, tap_state
    );
endinterface

// File: rtl/tap_fsm.sv
// rtl/tap_fsm.sv - 16-state TAP controller with boundary-scan strobes
module tap_fsm
    import tap_pkg::*;
(
    input  logic       tck_i,
    input  logic       trst_i,
    input  logic       tms_i,
    output tap_state_e state_o,
    output logic       clockdr_o,
    output logic       shiftdr_o,
    output logic       updatedr_o,
    output logic       clockir_o,
    output logic       shiftir_o,
    output logic       updateir_o,
    output logic       select_o,
    output logic       bs_en_o
);
    tap_state_e state_q;
    logic       shiftir_q;
    logic       bs_en_q;

    // Standard TAP transitions, sampled on rising TCK.
    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            state_q <= TEST_LOGIC_RESET;
        end else begin
            case (state_q)
                TEST_LOGIC_RESET: state_q <= tms_i ? TEST_LOGIC_RESET : RUN_IDLE;
                RUN_IDLE:         state_q <= tms_i ? SELECT_DR : RUN_IDLE;
                SELECT_DR:        state_q <= tms_i ? SELECT_IR : CAPTURE_DR;
                CAPTURE_DR:       state_q <= tms_i ? EXIT1_DR  : SHIFT_DR;
                SHIFT_DR:         state_q <= tms_i ? EXIT1_DR  : SHIFT_DR;
                EXIT1_DR:         state_q <= tms_i ? UPDATE_DR : PAUSE_DR;
                PAUSE_DR:         state_q <= tms_i ? EXIT2_DR  : PAUSE_DR;
                EXIT2_DR:         state_q <= tms_i ? UPDATE_DR : SHIFT_DR;
                UPDATE_DR:        state_q <= tms_i ? SELECT_DR : RUN_IDLE;
                SELECT_IR:        state_q <= tms_i ? TEST_LOGIC_RESET : CAPTURE_IR;
                CAPTURE_IR:       state_q <= tms_i ? EXIT1_IR  : SHIFT_IR;
                SHIFT_IR:         state_q <= tms_i ? EXIT1_IR  : SHIFT_IR;
                EXIT1_IR:         state_q <= tms_i ? UPDATE_IR : PAUSE_IR;
                PAUSE_IR:         state_q <= tms_i ? EXIT2_IR  : PAUSE_IR;
                EXIT2_IR:         state_q <= tms_i ? UPDATE_IR : SHIFT_IR;
                UPDATE_IR:        state_q <= tms_i ? SELECT_DR : RUN_IDLE;
                default:          state_q <= TEST_LOGIC_RESET;
            endcase
        end
    end

    // shiftir and bs_en change on falling TCK so they are stable across the next rising edge.
    always_ff @(negedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            shiftir_q <= 1'b0;
            bs_en_q   <= 1'b0;
        end else begin
            shiftir_q <= (state_q == SHIFT_IR);
            bs_en_q   <= (state_q != TEST_LOGIC_RESET);
        end
    end

    assign state_o    = state_q;
    assign clockdr_o  = ~tck_i & ((state_q == CAPTURE_DR) || (state_q == SHIFT_DR));
    assign shiftdr_o  = (state_q == SHIFT_DR);
    assign updatedr_o = ~tck_i & (state_q == UPDATE_DR);
    assign clockir_o  = ~tck_i & ((state_q == CAPTURE_IR) || (state_q == SHIFT_IR));
    assign shiftir_o  = shiftir_q;
    assign updateir_o = ~tck_i & (state_q == UPDATE_IR);
    assign select_o   = state_q[3];
    assign bs_en_o    = bs_en_q;
endmodule

// File: rtl/tap_controller_ir.sv
// rtl/tap_controller_ir.sv - TAP with IR, decode, bypass, optional IDCODE (IDCODE_EN) and TDO mux
module tap_controller_ir
    import tap_pkg::*;
#(
    parameter int          IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001,
    parameter int          OPC_EXTEST   = 0,
    parameter int          OPC_SAMPLE   = 1,
    parameter int          OPC_IDCODE   = 2
) (
    input logic               TCK,
    input logic               TRST,
    tap_controller_ir_if.slave jtag
);
    localparam logic [IR_WIDTH-1:0] OPC_EXTEST_W = IR_WIDTH'(OPC_EXTEST);
    localparam logic [IR_WIDTH-1:0] OPC_SAMPLE_W = IR_WIDTH'(OPC_SAMPLE);
    localparam logic [IR_WIDTH-1:0] OPC_IDCODE_W = IR_WIDTH'(OPC_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_CAP_W     = IR_WIDTH'(IR_CAPTURE);
`ifdef IDCODE_EN
    localparam logic [IR_WIDTH-1:0] RESET_INSTR  = OPC_IDCODE_W;
`else
    localparam logic [IR_WIDTH-1:0] RESET_INSTR  = IR_WIDTH'(bypass_opcode());
`endif

    tap_state_e          state;
    logic [IR_WIDTH-1:0] ir_q;
    logic [IR_WIDTH-1:0] instr_q;
    logic                bypass_q;
    logic                dr_tdo;
    logic                tdo_q;
    logic                tdo_en_q;

    tap_fsm u_fsm (
        .tck_i      (TCK),
        .trst_i     (TRST),
        .tms_i      (jtag.TMS),
        .state_o    (state),
        .clockdr_o  (jtag.clockdr),
        .shiftdr_o  (jtag.shiftdr),
        .updatedr_o (jtag.updatedr),
        .clockir_o  (jtag.clockir),
        .shiftir_o  (jtag.shiftir),
        .updateir_o (jtag.updateir),
        .select_o   (jtag.select),
        .bs_en_o    (jtag.bs_en)
    );

    // IR shift register and bypass bit capture/shift on rising TCK.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            ir_q     <= IR_CAP_W;
            bypass_q <= 1'b0;
        end else begin
            if (state == CAPTURE_IR) begin
                ir_q <= IR_CAP_W;
            end else if (state == SHIFT_IR) begin
                ir_q <= {jtag.TDI, ir_q[IR_WIDTH-1:1]};
            end
            if (state == CAPTURE_DR) begin
                bypass_q <= 1'b0;
            end else if (state == SHIFT_DR) begin
                bypass_q <= jtag.TDI;
            end
        end
    end

`ifdef IDCODE_EN
    logic [31:0] idcode_q;

    // Device ID register: reloads in Capture-DR, shifts LSB-first regardless of instruction.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            idcode_q <= IDCODE_VALUE;
        end else if (state == CAPTURE_DR) begin
            idcode_q <= IDCODE_VALUE;
        end else if (state == SHIFT_DR) begin
            idcode_q <= {jtag.TDI, idcode_q[31:1]};
        end
    end
`else
    // Without the ID register these only exist to keep the parameter list uniform.
    logic id_unused;
    assign id_unused = ^{IDCODE_VALUE, OPC_IDCODE_W};
`endif

    // Active instruction changes on falling TCK so the BSR never sees it mid-edge.
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            instr_q <= RESET_INSTR;
        end else if (state == TEST_LOGIC_RESET) begin
            instr_q <= RESET_INSTR;
        end else if (state == UPDATE_IR) begin
            instr_q <= ir_q;
        end
    end

    // Data-register select; unknown opcodes fall through to bypass.
    always_comb begin
        dr_tdo = bypass_q;
        if ((instr_q == OPC_EXTEST_W) || (instr_q == OPC_SAMPLE_W)) begin
            dr_tdo = jtag.bsr_tdo;
        end
`ifdef IDCODE_EN
        else if (instr_q == OPC_IDCODE_W) begin
            dr_tdo = idcode_q[0];
        end
`endif
    end

    // TDO is retimed to falling TCK; it holds its last value while not shifting.
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else if (state == SHIFT_IR) begin
            tdo_q    <= ir_q[0];
            tdo_en_q <= 1'b1;
        end else if (state == SHIFT_DR) begin
            tdo_q    <= dr_tdo;
            tdo_en_q <= 1'b1;
        end else begin
            tdo_en_q <= 1'b0;
        end
    end

    assign jtag.TDO       = tdo_q;
    assign jtag.tdo_en    = tdo_en_q;
    assign jtag.instr     = instr_q;
    assign jtag.tap_state = state;
    assign jtag.sel_bsr   = (instr_q == OPC_EXTEST_W) || (instr_q == OPC_SAMPLE_W);
    assign jtag.extest    = (instr_q == OPC_EXTEST_W);
endmodule
